// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 (7,5) hard-decision Viterbi decoder: default widths,
// the start-of-frame metric pattern and the trellis branch-label helper.
package viterbi_pkg;

  localparam int PM_W_DEF = 4;
  localparam int BM_W_DEF = 2;

  // Bit k set means state k starts a frame at PM_MAX; state 0 starts at zero.
  localparam logic [3:0] PM_INIT = 4'b1110;

  typedef logic [1:0] state_t;

  // Code pair {c0,c1} emitted when input bit u leaves state s = {u(t-1), u(t-2)}.
  function automatic logic [1:0] branch_idx(input state_t s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs_cell.sv
// One add-compare-select cell: extends both predecessor metrics by their branch
// metric with saturation and keeps the smaller, preferring the even predecessor on a tie.
module viterbi_acs_cell
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF,
  parameter int BM_W = BM_W_DEF
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [BM_W-1:0] i_bm0,
  input  logic [BM_W-1:0] i_bm1,
  output logic [PM_W-1:0] o_pm,
  output logic            o_dec,
  output logic            o_sat
);

  localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

  logic [PM_W:0]   sum0_s;
  logic [PM_W:0]   sum1_s;
  logic [PM_W-1:0] a0_s;
  logic [PM_W-1:0] a1_s;

  // Saturating adds; the extra carry bit flags a result above PM_MAX.
  always_comb begin
    sum0_s = {1'b0, i_pm0} + (PM_W+1)'(i_bm0);
    sum1_s = {1'b0, i_pm1} + (PM_W+1)'(i_bm1);
    if (sum0_s[PM_W]) begin
      a0_s = PM_MAX;
    end else begin
      a0_s = sum0_s[PM_W-1:0];
    end
    if (sum1_s[PM_W]) begin
      a1_s = PM_MAX;
    end else begin
      a1_s = sum1_s[PM_W-1:0];
    end
  end

  assign o_dec = (a1_s < a0_s);
  assign o_pm  = o_dec ? a1_s : a0_s;
  assign o_sat = sum0_s[PM_W] | sum1_s[PM_W];

endmodule

// File: rtl/viterbi_acsu.sv
// Add-compare-select unit: four ACS cells over the 4-state trellis, min-finder,
// normalisation and the path-metric/decision registers feeding traceback.
module viterbi_acsu
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF,
  parameter int BM_W = BM_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_start,
  input  logic [BM_W-1:0] i_bm_0,
  input  logic [BM_W-1:0] i_bm_1,
  input  logic [BM_W-1:0] i_bm_2,
  input  logic [BM_W-1:0] i_bm_3,
  output logic [PM_W-1:0] o_pm_0,
  output logic [PM_W-1:0] o_pm_1,
  output logic [PM_W-1:0] o_pm_2,
  output logic [PM_W-1:0] o_pm_3,
  output logic [3:0]      o_dec,
  output logic [1:0]      o_best,
  output logic            o_valid,
  output logic            o_sat
);

  localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

  logic [BM_W-1:0] bm_s  [4];
  logic [PM_W-1:0] old_s [4];
  logic [PM_W-1:0] sel_s [4];
  logic [PM_W-1:0] pm_d  [4];
  logic [PM_W-1:0] pm_q  [4];
  logic [PM_W-1:0] min_s;
  logic [3:0]      dec_s;
  logic [3:0]      sat_s;
  logic [1:0]      best_s;
  logic [3:0]      dec_q;
  logic [1:0]      best_q;
  logic            valid_q;
  logic            sat_q;

  assign bm_s[0] = i_bm_0;
  assign bm_s[1] = i_bm_1;
  assign bm_s[2] = i_bm_2;
  assign bm_s[3] = i_bm_3;

  // A frame start replaces the feedback metrics with the known-state-0 pattern.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (i_start) begin
        old_s[k] = PM_INIT[k] ? PM_MAX : {PM_W{1'b0}};
      end else begin
        old_s[k] = pm_q[k];
      end
    end
  end

  for (genvar ns = 0; ns < 4; ns++) begin : g_acs
    localparam state_t     P0 = state_t'(2 * (ns % 2));
    localparam state_t     P1 = state_t'(2 * (ns % 2) + 1);
    localparam logic       U  = 1'(ns / 2);
    localparam logic [1:0] K0 = branch_idx(P0, U);
    localparam logic [1:0] K1 = branch_idx(P1, U);

    viterbi_acs_cell #(.PM_W(PM_W), .BM_W(BM_W)) u_cell (
      .i_pm0 (old_s[P0]),
      .i_pm1 (old_s[P1]),
      .i_bm0 (bm_s[K0]),
      .i_bm1 (bm_s[K1]),
      .o_pm  (sel_s[ns]),
      .o_dec (dec_s[ns]),
      .o_sat (sat_s[ns])
    );
  end

  // Strict less-than keeps the lowest index on ties; the minimum is then subtracted everywhere.
  always_comb begin
    min_s  = sel_s[0];
    best_s = 2'd0;
    for (int k = 1; k < 4; k++) begin
      if (sel_s[k] < min_s) begin
        min_s  = sel_s[k];
        best_s = 2'(k);
      end else begin
        best_s = best_s;
      end
    end
    for (int k = 0; k < 4; k++) begin
      pm_d[k] = sel_s[k] - min_s;
    end
  end

  // State and output registers; o_sat restarts with each accepted frame start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) begin
        pm_q[k] <= PM_INIT[k] ? PM_MAX : {PM_W{1'b0}};
      end
      dec_q   <= 4'b0000;
      best_q  <= 2'd0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else if (i_valid) begin
      pm_q    <= pm_d;
      dec_q   <= dec_s;
      best_q  <= best_s;
      valid_q <= 1'b1;
      sat_q   <= i_start ? (|sat_s) : (sat_q | (|sat_s));
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign o_pm_0  = pm_q[0];
  assign o_pm_1  = pm_q[1];
  assign o_pm_2  = pm_q[2];
  assign o_pm_3  = pm_q[3];
  assign o_dec   = dec_q;
  assign o_best  = best_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_viterbi_acsu.sv
// Bench for viterbi_acsu: a trellis-level reference model updated on every clock, a
// per-cycle compare process, hand-derived literal checks and a long random coded stream.
module tb_viterbi_acsu;

  localparam int PMMAX = 15;

  logic       i_clk = 1'b0;
  logic       i_rst, i_valid, i_start;
  logic [1:0] i_bm_0, i_bm_1, i_bm_2, i_bm_3;
  logic [3:0] o_pm_0, o_pm_1, o_pm_2, o_pm_3;
  logic [3:0] o_dec;
  logic [1:0] o_best;
  logic       o_valid, o_sat;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_pm [4];
  int m_dec, m_best, m_valid, m_sat;

  viterbi_acsu #(.PM_W(4), .BM_W(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_start(i_start),
    .i_bm_0(i_bm_0), .i_bm_1(i_bm_1), .i_bm_2(i_bm_2), .i_bm_3(i_bm_3),
    .o_pm_0(o_pm_0), .o_pm_1(o_pm_1), .o_pm_2(o_pm_2), .o_pm_3(o_pm_3),
    .o_dec(o_dec), .o_best(o_best), .o_valid(o_valid), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one trellis step from the encoder's (7,5) generator view.
  always @(posedge i_clk) begin
    int old [4];
    int bmv [4];
    int cand [2];
    int sel [4];
    int mn, any_sat;
    if (i_rst) begin
      m_pm = '{0, PMMAX, PMMAX, PMMAX};
      m_dec = 0; m_best = 0; m_valid = 0; m_sat = 0;
    end else if (i_valid) begin
      bmv = '{int'(i_bm_0), int'(i_bm_1), int'(i_bm_2), int'(i_bm_3)};
      for (int k = 0; k < 4; k++) old[k] = i_start ? ((k == 0) ? 0 : PMMAX) : m_pm[k];
      any_sat = 0;
      m_dec = 0;
      for (int ns = 0; ns < 4; ns++) begin
        int u;
        u = ns / 2;
        for (int j = 0; j < 2; j++) begin
          int p, u1, u2, c0, c1, sum;
          p   = 2 * (ns % 2) + j;
          u1  = p / 2;
          u2  = p % 2;
          c0  = u ^ u1 ^ u2;
          c1  = u ^ u2;
          sum = old[p] + bmv[2 * c0 + c1];
          if (sum > PMMAX) begin sum = PMMAX; any_sat = 1; end
          cand[j] = sum;
        end
        if (cand[1] < cand[0]) begin m_dec += (1 << ns); sel[ns] = cand[1]; end
        else sel[ns] = cand[0];
      end
      mn = sel[0]; m_best = 0;
      for (int k = 1; k < 4; k++) if (sel[k] < mn) begin mn = sel[k]; m_best = k; end
      for (int k = 0; k < 4; k++) m_pm[k] = sel[k] - mn;
      m_valid = 1;
      m_sat = i_start ? any_sat : (m_sat | any_sat);
    end else begin
      m_valid = 0;
    end
  end

  // Every cycle after reset, all outputs must match the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("pm0", o_pm_0, m_pm[0]);
      chk("pm1", o_pm_1, m_pm[1]);
      chk("pm2", o_pm_2, m_pm[2]);
      chk("pm3", o_pm_3, m_pm[3]);
      chk("dec", o_dec, m_dec);
      chk("best", o_best, m_best);
      chk("valid", o_valid, m_valid);
      chk("sat", o_sat, m_sat);
    end
  end

  task automatic drive_rx(input bit v, input bit s, input bit r, input int rx);
    int bm [4];
    for (int k = 0; k < 4; k++) bm[k] = $countones(rx ^ k);
    @(negedge i_clk);
    i_valid = v; i_start = s; i_rst = r;
    i_bm_0 = 2'(bm[0]); i_bm_1 = 2'(bm[1]); i_bm_2 = 2'(bm[2]); i_bm_3 = 2'(bm[3]);
  endtask

  task automatic after_edge();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int enc, since_err, rx, u;
    bit v, s, r;
    i_rst = 1'b1; i_valid = 1'b0; i_start = 1'b0;
    i_bm_0 = 2'd0; i_bm_1 = 2'd0; i_bm_2 = 2'd0; i_bm_3 = 2'd0;
    after_edge();
    chk_en = 1'b1;
    chk("rst_pm1", o_pm_1, 15);
    chk("rst_valid", o_valid, 0);

    // rx 00 from INIT: bm = {0,1,1,2}
    drive_rx(1'b1, 1'b1, 1'b0, 0);
    after_edge();
    chk("t1_pm0", o_pm_0, 0);  chk("t1_pm1", o_pm_1, 15);
    chk("t1_pm2", o_pm_2, 2);  chk("t1_pm3", o_pm_3, 15);
    chk("t1_dec", o_dec, 0);   chk("t1_best", o_best, 0);
    chk("t1_valid", o_valid, 1); chk("t1_sat", o_sat, 1);

    // Noiseless u=1,0,1,1 -> states 2,1,2,3
    drive_rx(1'b1, 1'b1, 1'b0, 3); after_edge(); chk("t2_best_a", o_best, 2);
    drive_rx(1'b1, 1'b0, 1'b0, 2); after_edge(); chk("t2_best_b", o_best, 1);
    drive_rx(1'b1, 1'b0, 1'b0, 0); after_edge(); chk("t2_best_c", o_best, 2);
    chk("t2_dec_c", o_dec, 15);
    drive_rx(1'b1, 1'b0, 1'b0, 1); after_edge(); chk("t2_best_d", o_best, 3);
    chk("t2_pm0", o_pm_0, 3); chk("t2_pm3", o_pm_3, 0);

    // Idle gap with a stray start: everything holds
    for (int i = 0; i < 3; i++) drive_rx(1'b0, (i == 1), 1'b0, 0);
    after_edge();
    chk("gap_valid", o_valid, 0); chk("gap_best", o_best, 3);
    drive_rx(1'b1, 1'b0, 1'b0, 2);

    // Reset wins over a valid symbol
    drive_rx(1'b1, 1'b0, 1'b1, 3);
    after_edge();
    chk("t5_pm0", o_pm_0, 0); chk("t5_pm2", o_pm_2, 15);
    chk("t5_valid", o_valid, 0); chk("t5_sat", o_sat, 0);

    // Random coded stream, at most one bit error per five symbols
    enc = 0; since_err = 0;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 5) != 0);
      s = (i == 0) || ($urandom_range(0, 60) == 0);
      r = (i == 500);
      rx = $urandom_range(0, 3);
      if (r || (v && s)) enc = 0;
      if (v && !r) begin
        u  = $urandom_range(0, 1);
        rx = 2 * (u ^ (enc / 2) ^ (enc % 2)) + (u ^ (enc % 2));
        since_err++;
        if (since_err >= 5 && $urandom_range(0, 2) == 0) begin
          rx = rx ^ (1 << $urandom_range(0, 1));
          since_err = 0;
        end
        enc = 2 * u + (enc / 2);
      end
      drive_rx(v, s, r, rx);
    end
    drive_rx(1'b0, 1'b0, 1'b0, 0);
    after_edge();
    @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
